// File: rtl/sized_ram.sv
// Byte-addressed big-endian RAM with sized (1/2/4/8 byte) accesses, range/alignment checking and a debug byte port.
// Latency: LATENCY cycles from request acceptance to the one-cycle ready pulse; dataOut registered on the same edge.
// Backpressure: single outstanding access; request is only sampled in IDLE, so busy must be low before a new request lands.
module sized_ram #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64,
    parameter int LATENCY       = 2,
    parameter int ALIGN_CHECK   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     request,
    input  logic                     isReading,
    input  logic [1:0]               accessSize,
    input  logic                     signExtend,
    input  logic [ADDRESS_SIZE-1:0]  address,
    input  logic [MEM_WORD_SIZE-1:0] dataIn,
    output logic [MEM_WORD_SIZE-1:0] dataOut,
    output logic                     ready,
    output logic                     busy,
    output logic                     addrError,
    input  logic [ADDRESS_SIZE-1:0]  debugAddress,
    output logic [7:0]               debugOut
);

    localparam int         DEPTH     = 2**ADDRESS_SIZE;
    localparam int         MAX_BYTES = MEM_WORD_SIZE / 8;
    localparam logic [3:0] CNT_LOAD  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_count;
    logic [3:0]               w_count_next;

    logic                     r_is_read;
    logic                     r_sext;
    logic [1:0]               r_size;
    logic [ADDRESS_SIZE-1:0]  r_addr;
    logic [MEM_WORD_SIZE-1:0] r_data;

    logic [MEM_WORD_SIZE-1:0] r_dout;
    logic                     r_err;

    logic [7:0]               r_mem [DEPTH];

    // Transaction view: live inputs on the acceptance edge, latched copy afterwards.
    // This lets LATENCY=1 commit on the acceptance edge itself.
    logic                     w_t_read;
    logic                     w_t_sext;
    logic [1:0]               w_t_size;
    logic [ADDRESS_SIZE-1:0]  w_t_addr;
    logic [63:0]              w_t_data;

    logic                     w_accept;
    logic                     w_commit;
    logic [3:0]               w_nbytes;
    logic [6:0]               w_nbits;
    logic [ADDRESS_SIZE:0]    w_end;
    logic [2:0]               w_low;
    logic                     w_overflow;
    logic                     w_misalign;
    logic                     w_oversize;
    logic                     w_err;

    logic [63:0]              w_field;
    logic [63:0]              w_mask;
    logic [5:0]               w_msb_idx;
    logic [63:0]              w_rdata;

    assign w_accept = (r_state == IDLE) && request;

    assign w_t_read = (r_state == IDLE) ? isReading  : r_is_read;
    assign w_t_sext = (r_state == IDLE) ? signExtend : r_sext;
    assign w_t_size = (r_state == IDLE) ? accessSize : r_size;
    assign w_t_addr = (r_state == IDLE) ? address    : r_addr;
    assign w_t_data = (r_state == IDLE) ? 64'(dataIn) : 64'(r_data);

    assign w_nbytes = 4'd1 << w_t_size;
    assign w_nbits  = {w_nbytes, 3'b000};

    // The end address needs one extra bit so a field running past the top is seen, not wrapped.
    assign w_end      = {1'b0, w_t_addr} + (ADDRESS_SIZE + 1)'(w_nbytes);
    assign w_overflow = w_end[ADDRESS_SIZE] && (w_end[ADDRESS_SIZE-1:0] != '0);
    assign w_low      = 3'(w_t_addr);
    assign w_misalign = (ALIGN_CHECK != 0) && ((w_low & (w_nbytes[2:0] - 3'd1)) != 3'd0);
    assign w_oversize = int'(w_nbytes) > MAX_BYTES;
    assign w_err      = w_overflow || w_misalign || w_oversize;

    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (request) begin
                    if (LATENCY > 1) begin
                        w_next       = WAIT;
                        w_count_next = CNT_LOAD;
                    end else begin
                        w_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_commit = (w_next == RESP) && (r_state != RESP);

    // Big-endian gather: the lowest address lands in the most significant byte of the field.
    always_comb begin
        w_field = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(w_nbytes)) begin
                w_field = {w_field[55:0], r_mem[w_t_addr + ADDRESS_SIZE'(i)]};
            end
        end
    end

    assign w_mask    = (64'd1 << w_nbits) - 64'd1;
    assign w_msb_idx = 6'(w_nbits - 7'd1);
    assign w_rdata   = (w_t_sext && w_field[w_msb_idx]) ? (w_field | ~w_mask) : w_field;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            if (w_commit) begin
                r_err  <= w_err;
                r_dout <= (w_t_read && !w_err) ? w_rdata[MEM_WORD_SIZE-1:0] : '0;
            end else if (r_state == RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_read <= isReading;
            r_sext    <= signExtend;
            r_size    <= accessSize;
            r_addr    <= address;
            r_data    <= dataIn;
        end
    end

    // Storage is deliberately unreset; a write only lands on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_commit && !w_t_read && !w_err && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(w_nbytes)) begin
                    r_mem[w_t_addr + ADDRESS_SIZE'(i)] <= w_t_data[8*(int'(w_nbytes)-1-i) +: 8];
                end
            end
        end
    end

    assign dataOut   = r_dout;
    assign ready     = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign addrError = r_err;
    assign debugOut  = r_mem[debugAddress];

endmodule

// File: tb/tb_sized_ram.sv
// Bench for sized_ram: two instances (LATENCY=2/no align check, LATENCY=3/align check) driven in lockstep
// and compared against a byte-array reference model per instance.
module tb_sized_ram;

    logic        clk;
    logic        reset;
    logic        request;
    logic        isReading;
    logic [1:0]  accessSize;
    logic        signExtend;
    logic [10:0] address;
    logic [63:0] dataIn;
    logic [10:0] debugAddress;

    wire  [1:0]  ready_v;
    wire  [1:0]  busy_v;
    wire  [1:0]  err_v;
    wire  [63:0] dout_v [2];
    wire  [7:0]  dbg_v  [2];

    int n_pass;
    int n_total;

    logic [7:0]  mem_m [2][2048];
    int          lat   [2] = '{2, 3};

    logic        exp_err  [2];
    logic [63:0] exp_dout [2];
    int          rk   [2];
    int          rcnt [2];
    int          bcnt [2];
    logic        rerr [2];
    logic [63:0] rdout[2];
    logic [63:0] dend [2];

    sized_ram u0 (
        .clk(clk), .reset(reset), .request(request), .isReading(isReading),
        .accessSize(accessSize), .signExtend(signExtend), .address(address),
        .dataIn(dataIn), .dataOut(dout_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .addrError(err_v[0]), .debugAddress(debugAddress), .debugOut(dbg_v[0])
    );

    sized_ram #(.LATENCY(3), .ALIGN_CHECK(1)) u1 (
        .clk(clk), .reset(reset), .request(request), .isReading(isReading),
        .accessSize(accessSize), .signExtend(signExtend), .address(address),
        .dataIn(dataIn), .dataOut(dout_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .addrError(err_v[1]), .debugAddress(debugAddress), .debugOut(dbg_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory is a plain byte array, fields are read/written MSB-first from the start address.
    function automatic void model_op(input int d, input logic rd, input logic [1:0] sz, input logic sx,
                                     input int addr, input logic [63:0] din,
                                     output logic err, output logic [63:0] dout);
        int nb;
        nb   = 1 << sz;
        err  = (addr + nb > 2048) || (d == 1 && (addr % nb) != 0);
        dout = 64'd0;
        if (!err) begin
            if (rd) begin
                for (int i = 0; i < nb; i++) dout = (dout << 8) | 64'(mem_m[d][addr + i]);
                if (sx && dout[8*nb-1]) begin
                    for (int b = 8*nb; b < 64; b++) dout[b] = 1'b1;
                end
            end else begin
                for (int i = 0; i < nb; i++) mem_m[d][addr + i] = din[8*(nb-1-i) +: 8];
            end
        end
    endfunction

    task automatic do_access(input logic rd, input logic [1:0] sz, input logic sx,
                             input int addr, input logic [63:0] din, input logic hold);
        logic        e;
        logic [63:0] o;
        for (int d = 0; d < 2; d++) begin
            model_op(d, rd, sz, sx, addr, din, e, o);
            exp_err[d]  = e;
            exp_dout[d] = o;
            rk[d] = 0; rcnt[d] = 0; bcnt[d] = 0; rerr[d] = 1'b0; rdout[d] = 64'd0;
        end
        isReading  = rd;
        accessSize = sz;
        signExtend = sx;
        address    = 11'(addr);
        dataIn     = din;
        request    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) request = 1'b0;
        address    = 11'($urandom);
        dataIn     = {$urandom, $urandom};
        isReading  = 1'($urandom);
        accessSize = 2'($urandom);
        signExtend = 1'($urandom);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) request = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (ready_v[d]) begin
                    rcnt[d]++;
                    rk[d]    = k;
                    rerr[d]  = err_v[d];
                    rdout[d] = dout_v[d];
                end
                if (busy_v[d]) bcnt[d]++;
                if (k == 7) dend[d] = dout_v[d];
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        request    = 1'b1;
        isReading  = 1'b0;
        accessSize = 2'd3;
        signExtend = 1'b0;
        address    = 11'd0;
        dataIn     = {$urandom, $urandom};
        debugAddress = 11'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({ready_v[d], busy_v[d], err_v[d]} !== 3'b000)
                $display("FAIL reset_ctrl[%0d]: got rdy/busy/err=%b want 000", d, {ready_v[d], busy_v[d], err_v[d]});
            else n_pass++;
            n_total++;
            if (dout_v[d] !== 64'd0) $display("FAIL reset_dout[%0d]: got %h want 0", d, dout_v[d]);
            else n_pass++;
        end
        reset = 1'b0;
        do_access(1'b0, 2'd3, 1'b0, 0, {$urandom, $urandom}, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rk[d] !== lat[d] || rcnt[d] !== 1)
                $display("FAIL first_after_reset[%0d]: ready at cycle %0d (count %0d) want cycle %0d once", d, rk[d], rcnt[d], lat[d]);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        for (int a = 0; a < 2048; a += 8) begin
            do_access(1'b0, 2'd3, 1'b0, a, {$urandom, $urandom}, 1'b0);
            for (int d = 0; d < 2; d++) if (rcnt[d] != 1 || rerr[d] !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL fill: %0d bad completions want 0", bad);
        else n_pass++;
    endtask

    task automatic test_endianness();
        do_access(1'b0, 2'd3, 1'b0, 24, 64'h0102030405060708, 1'b0);
        do_access(1'b1, 2'd0, 1'b0, 24, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdout[d] !== 64'h01) $display("FAIL byte_read24[%0d]: got %h want 01", d, rdout[d]);
            else n_pass++;
        end
        do_access(1'b1, 2'd1, 1'b0, 30, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdout[d] !== 64'h0708) $display("FAIL half_read30[%0d]: got %h want 0708", d, rdout[d]);
            else n_pass++;
        end
        debugAddress = 11'd27;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (dbg_v[d] !== 8'h04) $display("FAIL debug27[%0d]: got %h want 04", d, dbg_v[d]);
            else n_pass++;
        end
    endtask

    task automatic test_sign_extend();
        do_access(1'b0, 2'd0, 1'b0, 5, 64'h80, 1'b0);
        do_access(1'b1, 2'd0, 1'b1, 5, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdout[d] !== 64'hFFFFFFFFFFFFFF80) $display("FAIL sext_on[%0d]: got %h want FFFFFFFFFFFFFF80", d, rdout[d]);
            else n_pass++;
        end
        do_access(1'b1, 2'd0, 1'b0, 5, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdout[d] !== 64'h80) $display("FAIL sext_off[%0d]: got %h want 80", d, rdout[d]);
            else n_pass++;
        end
    endtask

    task automatic test_latency_hold();
        do_access(1'b1, 2'd2, 1'b0, 64, 64'd0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rk[d] !== lat[d] || rcnt[d] !== 1)
                $display("FAIL latency[%0d]: ready at cycle %0d (count %0d) want cycle %0d once", d, rk[d], rcnt[d], lat[d]);
            else n_pass++;
            n_total++;
            if (bcnt[d] !== lat[d]) $display("FAIL busy_len[%0d]: got %0d want %0d", d, bcnt[d], lat[d]);
            else n_pass++;
            n_total++;
            if (rdout[d] !== exp_dout[d]) $display("FAIL hold_read[%0d]: got %h want %h", d, rdout[d], exp_dout[d]);
            else n_pass++;
        end
    endtask

    task automatic test_bounds();
        logic [7:0] old [2][4];
        for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) old[d][i] = mem_m[d][2044 + i];
        do_access(1'b1, 2'd3, 1'b0, 2044, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rerr[d] !== 1'b1 || rdout[d] !== 64'd0)
                $display("FAIL oob_read[%0d]: got err=%b dout=%h want err=1 dout=0", d, rerr[d], rdout[d]);
            else n_pass++;
        end
        do_access(1'b0, 2'd3, 1'b0, 2044, 64'hDEADBEEFCAFEF00D, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rerr[d] !== 1'b1 || rdout[d] !== 64'd0)
                $display("FAIL oob_write[%0d]: got err=%b dout=%h want err=1 dout=0", d, rerr[d], rdout[d]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            debugAddress = 11'(2044 + i);
            #1;
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (dbg_v[d] !== old[d][i]) $display("FAIL oob_untouched[%0d] @%0d: got %h want %h", d, 2044 + i, dbg_v[d], old[d][i]);
                else n_pass++;
            end
        end
        do_access(1'b1, 2'd1, 1'b0, 2046, 64'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rerr[d] !== 1'b0 || rdout[d] !== exp_dout[d])
                $display("FAIL top_half[%0d]: got err=%b dout=%h want err=0 dout=%h", d, rerr[d], rdout[d], exp_dout[d]);
            else n_pass++;
        end
    endtask

    task automatic test_align();
        do_access(1'b1, 2'd2, 1'b0, 2, 64'd0, 1'b0);
        n_total++;
        if (rerr[0] !== 1'b0 || rdout[0] !== exp_dout[0])
            $display("FAIL misalign_ok: got err=%b dout=%h want err=0 dout=%h", rerr[0], rdout[0], exp_dout[0]);
        else n_pass++;
        n_total++;
        if (rerr[1] !== 1'b1 || rdout[1] !== 64'd0)
            $display("FAIL misalign_err: got err=%b dout=%h want err=1 dout=0", rerr[1], rdout[1]);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int         seen [2];
        logic [7:0] old  [2][8];
        for (int d = 0; d < 2; d++) begin
            seen[d] = 0;
            for (int i = 0; i < 8; i++) old[d][i] = mem_m[d][104 + i];
        end
        isReading  = 1'b0;
        accessSize = 2'd3;
        signExtend = 1'b0;
        address    = 11'd104;
        dataIn     = ~{old[0][0], old[0][1], old[0][2], old[0][3], old[0][4], old[0][5], old[0][6], old[0][7]};
        request    = 1'b1;
        @(posedge clk);
        #1 request = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (busy_v[d] !== 1'b0) $display("FAIL abort_busy[%0d]: got %b want 0", d, busy_v[d]);
            else n_pass++;
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (ready_v[d]) seen[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (seen[d] != 0) $display("FAIL abort_ready[%0d]: got %0d pulses want 0", d, seen[d]);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            debugAddress = 11'(104 + i);
            #1;
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (dbg_v[d] !== old[d][i]) $display("FAIL abort_mem[%0d] @%0d: got %h want %h", d, 104 + i, dbg_v[d], old[d][i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic       rd;
        logic [1:0] sz;
        int         addr;
        int         da;
        for (int n = 0; n < 200; n++) begin
            rd   = 1'($urandom);
            sz   = 2'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? 2040 + $urandom_range(0, 7) : $urandom_range(0, 2047);
            do_access(rd, sz, 1'($urandom), addr, {$urandom, $urandom}, 1'($urandom));
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (rk[d] !== lat[d] || rcnt[d] !== 1 || bcnt[d] !== lat[d])
                    $display("FAIL rnd_timing[%0d] op%0d: ready cyc %0d cnt %0d busy %0d want %0d/1/%0d", d, n, rk[d], rcnt[d], bcnt[d], lat[d], lat[d]);
                else n_pass++;
                n_total++;
                if (rerr[d] !== exp_err[d]) $display("FAIL rnd_err[%0d] op%0d: got %b want %b", d, n, rerr[d], exp_err[d]);
                else n_pass++;
                n_total++;
                if (rdout[d] !== exp_dout[d]) $display("FAIL rnd_dout[%0d] op%0d: got %h want %h", d, n, rdout[d], exp_dout[d]);
                else n_pass++;
                n_total++;
                if (dend[d] !== exp_dout[d]) $display("FAIL rnd_hold[%0d] op%0d: got %h want %h", d, n, dend[d], exp_dout[d]);
                else n_pass++;
            end
            da = $urandom_range(0, 2047);
            debugAddress = 11'(da);
            #1;
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (dbg_v[d] !== mem_m[d][da]) $display("FAIL rnd_debug[%0d] @%0d: got %h want %h", d, da, dbg_v[d], mem_m[d][da]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fill();
        test_endianness();
        test_sign_extend();
        test_latency_hold();
        test_bounds();
        test_align();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sized_ram.md
SIZED_RAM -- requirements
Module: sized_ram

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 11, byte-address width; memory depth is 2**ADDRESS_SIZE bytes.
REQ-002 SHALL have parameter MEM_WORD_SIZE, default 64, data port width in bits; legal values are 16, 32 and 64.
REQ-003 SHALL have parameter LATENCY, default 2, the number of cycles from request acceptance to ready; legal values are 1 to 15.
REQ-004 SHALL have parameter ALIGN_CHECK, default 0; when 1, a misaligned access is an error.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port request, input, 1 bit, access request, sampled only in IDLE.
REQ-008 SHALL have port isReading, input, 1 bit: 1 selects read, 0 selects write.
REQ-009 SHALL have port accessSize, input, 2 bits, giving 2**accessSize bytes: 0=byte, 1=half, 2=word, 3=double; must not exceed MEM_WORD_SIZE/8.
REQ-010 SHALL have port signExtend, input, 1 bit, sign-extending read data when 1.
REQ-011 SHALL have port address, input, ADDRESS_SIZE bits, start byte address.
REQ-012 SHALL have port dataIn, input, MEM_WORD_SIZE bits, write data, right-justified.
REQ-013 SHALL have port dataOut, output, MEM_WORD_SIZE bits, read data, registered.
REQ-014 SHALL have port ready, output, 1 bit, one-cycle completion pulse.
REQ-015 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-016 SHALL have port addrError, output, 1 bit, qualified by ready: the completed access was rejected.
REQ-017 SHALL have port debugAddress, input, ADDRESS_SIZE bits, debug byte address.
REQ-018 SHALL have port debugOut, output, 8 bits, combinational byte at debugAddress, regardless of state.

Function
REQ-019 SHALL store bytes big-endian: the most-significant byte of the accessed field is at the lowest address.
REQ-020 SHALL implement states IDLE, WAIT and RESP.
REQ-021 SHALL, in IDLE with request=1 at a clock edge, latch isReading, accessSize, signExtend, address and dataIn, then enter WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-022 SHALL remain in WAIT for LATENCY-1 cycles, counted by an internal down-counter, then enter RESP.
REQ-023 SHALL assert ready for exactly one cycle while in RESP, i.e. LATENCY cycles after the acceptance edge, then return to IDLE.
REQ-024 SHALL ignore request in WAIT and RESP, with no queuing; a new request is accepted at the earliest on the first edge in IDLE after RESP.
REQ-025 SHALL commit writes on the edge entering RESP; inputs changing after acceptance have no effect.
REQ-026 SHALL, on a read, place the field in dataOut[8*2**accessSize-1:0], filling upper bits with zero, or with the field MSB when signExtend=1.
REQ-027 SHALL flag an error when address + 2**accessSize > 2**ADDRESS_SIZE, so that no wrap-around occurs.
REQ-028 SHALL flag an error when ALIGN_CHECK=1 and address is not a multiple of 2**accessSize; with ALIGN_CHECK=0, misaligned accesses proceed.
REQ-029 SHALL, on an error, assert addrError with ready, write no bytes, and drive dataOut to 0.
REQ-030 SHALL hold dataOut stable from RESP until the next RESP; after a write completion, dataOut is 0.
REQ-031 SHALL write only 2**accessSize bytes, taken from dataIn[8*2**accessSize-1:0]; other memory bytes are unchanged.

Reset
REQ-032 SHALL, while reset is high, force state to IDLE, counter to 0, and ready, busy, addrError and dataOut to 0, asynchronously.
REQ-033 SHALL leave memory contents unchanged on reset; a write aborted by reset before the RESP edge commits nothing.
REQ-034 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL cover: double write 0x0102030405060708 at address 24, then byte read at 24 -> dataOut=0x01, and half read at 30 -> 0x0708; debugOut at 27 = 0x04.
REQ-036 SHALL cover: byte 0x80 at address 5, read with signExtend=1 -> 0xFFFFFFFFFFFFFF80; with signExtend=0 -> 0x80.
REQ-037 SHALL cover, with LATENCY=3: ready high exactly 3 cycles after the acceptance edge, busy high for 3 cycles, and a request held high during busy ignored.
REQ-038 SHALL cover: double access at address 2044 (ADDRESS_SIZE=11) -> ready with addrError=1, dataOut=0, bytes 2044-2047 unchanged.
REQ-039 SHALL cover, with ALIGN_CHECK=1: word access at address 2 -> addrError=1; with ALIGN_CHECK=0, the same access completes normally.
REQ-040 SHALL cover: write accepted, reset pulsed during WAIT -> ready never asserted, and target bytes keep their old values.
